// File: rtl/qm_tx_if.sv
// Egress bundle of the queue manager: pointer/data FIFO read ports and the
// framed byte stream toward the port transmitter.
interface qm_tx_if;
  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        tx_sof;
  logic        tx_dv;
  logic [7:0]  tx_data;

  modport master (
    input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout,
    output ptr_fifo_rd, data_fifo_rd, tx_sof, tx_dv, tx_data
  );

  modport slave (
    output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout,
    input  ptr_fifo_rd, data_fifo_rd, tx_sof, tx_dv, tx_data
  );
endinterface

// File: rtl/qm_tx.sv
// Queue-manager egress reader: pops a length descriptor, streams that many
// payload bytes as a framed stream with optional length/port header and IFG.
module qm_tx #(
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [3:0]  PORT_ID = 4'b0001,
  parameter int unsigned IFG     = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_hold,
  qm_tx_if.master     bus,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_zero_len
);

  localparam logic [11:0] IFG_CNT = 12'(IFG);

  // Header byte0 is loaded while in PTR and byte1 in the first DATA cycle,
  // so HDR0/HDR1 overlap PTR/DATA and need no states of their own.
  typedef enum logic [2:0] {IDLE, PTR, DATA, DRAIN, GAP} state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt;
  logic [11:0] len_in;
  logic [11:0] hl_in;
  logic [7:0]  hl_lo_q;
  logic        rd_d;
  logic        unused_desc;

  assign len_in      = bus.ptr_fifo_dout[11:0];
  assign hl_in       = len_in + 12'd2;
  assign unused_desc = &{1'b0, bus.ptr_fifo_dout[15:12]};
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.ptr_fifo_rd  = 1'b0;
    bus.data_fifo_rd = 1'b0;
    err_zero_len     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.ptr_fifo_empty && !tx_hold) begin
          bus.ptr_fifo_rd = 1'b1;
          state_nxt       = PTR;
        end
      end
      PTR: begin
        if (len_in == '0) begin
          err_zero_len = 1'b1;
          state_nxt    = IDLE;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        bus.data_fifo_rd = 1'b1;
        if (cnt == 12'd1) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == 12'd1) state_nxt = (IFG == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (cnt == 12'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One down-counter serves the byte count, the drain and the gap in turn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      hl_lo_q <= '0;
    end else begin
      unique case (state)
        PTR: begin
          cnt     <= len_in;
          hl_lo_q <= hl_in[7:0];
        end
        DATA:    cnt <= (cnt == 12'd1) ? 12'd2 : cnt - 12'd1;
        DRAIN:   cnt <= (cnt == 12'd1) ? IFG_CNT : cnt - 12'd1;
        GAP:     cnt <= cnt - 12'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // rd_d marks data_fifo_dout as valid this cycle (one-cycle read latency).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_d        <= 1'b0;
      bus.tx_sof  <= 1'b0;
      bus.tx_dv   <= 1'b0;
      bus.tx_data <= '0;
      frame_cnt   <= '0;
    end else begin
      rd_d        <= bus.data_fifo_rd;
      bus.tx_sof  <= 1'b0;
      bus.tx_dv   <= 1'b0;
      bus.tx_data <= '0;
      if (HDR_EN && state == PTR && len_in != '0) begin
        bus.tx_sof  <= 1'b1;
        bus.tx_dv   <= 1'b1;
        bus.tx_data <= {hl_in[11:8], PORT_ID};
      end else if (HDR_EN && state == DATA && bus.tx_sof) begin
        bus.tx_dv   <= 1'b1;
        bus.tx_data <= hl_lo_q;
      end else if (rd_d) begin
        bus.tx_sof  <= !HDR_EN && !bus.tx_dv;
        bus.tx_dv   <= 1'b1;
        bus.tx_data <= bus.data_fifo_dout;
      end
      if (rd_d && state == DRAIN) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_qm_tx.sv
// Scoreboard bench for qm_tx: two instances (header on / header off) fed by
// queue-based FIFO models; expected bytes carry their cycle offset from the pointer read.
module tb_qm_tx;

  typedef struct {
    bit         sof;
    logic [7:0] data;
    int         off;
    int         fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        hold0 = 1'b0;
  logic        hold1 = 1'b0;
  logic        busy0, busy1, err0, err1;
  logic [15:0] fc0, fc1;

  qm_tx_if bus0 ();
  qm_tx_if bus1 ();

  qm_tx #(.HDR_EN(1'b1), .PORT_ID(4'b0001), .IFG(12)) dut0 (
    .clk(clk), .rstn(rstn), .tx_hold(hold0), .bus(bus0),
    .busy(busy0), .frame_cnt(fc0), .err_zero_len(err0)
  );

  qm_tx #(.HDR_EN(1'b0), .PORT_ID(4'b0001), .IFG(3)) dut1 (
    .clk(clk), .rstn(rstn), .tx_hold(hold1), .bus(bus1),
    .busy(busy1), .frame_cnt(fc1), .err_zero_len(err1)
  );

  always #5 clk = ~clk;

  logic [15:0] pq0[$], pq1[$];
  logic [7:0]  dq0[$], dq1[$];
  exp_t        eq0[$], eq1[$];

  int cyc = 0, checks = 0, failures = 0;
  int c0_0 = 0, c0_1 = 0, rd_cnt0 = 0, rd_gap0 = 0;
  int err_cnt0 = 0, err_off0 = 0, dv_cnt0 = 0;
  int sof_gap1 = 0, last_sof1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_byte(input string nm, input exp_t e, input logic sof,
                          input logic [7:0] d, input int off, input logic [15:0] fc);
    chk({nm, "_data"}, d, e.data);
    chk({nm, "_sof"}, sof, e.sof);
    chk({nm, "_cycle"}, off, e.off);
    if (e.fc >= 0) chk({nm, "_frame_cnt"}, fc, e.fc);
  endtask

  task automatic ex(input int d, input bit sof, input logic [7:0] data, input int off, input int fc);
    exp_t e;
    e.sof = sof; e.data = data; e.off = off; e.fc = fc;
    if (d == 0) eq0.push_back(e);
    else        eq1.push_back(e);
  endtask

  task automatic wait_done(input int d, input int budget, input string nm);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk); #1;
      if (d == 0) done = (eq0.size() == 0) && !busy0 && bus0.ptr_fifo_empty;
      else        done = (eq1.size() == 0) && !busy1 && bus1.ptr_fifo_empty;
    end
    chk(nm, done, 1);
  endtask

  // FIFO models: registered read data, empty flag follows the queue at the clock edge.
  always @(posedge clk) begin
    cyc++;
    if (bus0.ptr_fifo_rd && pq0.size() > 0) bus0.ptr_fifo_dout <= pq0.pop_front();
    if (bus0.data_fifo_rd && dq0.size() > 0) bus0.data_fifo_dout <= dq0.pop_front();
    if (bus1.ptr_fifo_rd && pq1.size() > 0) bus1.ptr_fifo_dout <= pq1.pop_front();
    if (bus1.data_fifo_rd && dq1.size() > 0) bus1.data_fifo_dout <= dq1.pop_front();
    bus0.ptr_fifo_empty <= (pq0.size() == 0);
    bus1.ptr_fifo_empty <= (pq1.size() == 0);
  end

  // Monitor: samples on the falling edge and pops the scoreboard on every valid byte.
  always @(negedge clk) begin
    exp_t e;
    if (err0) begin err_cnt0++; err_off0 = cyc - c0_0; end
    if (bus0.ptr_fifo_rd) begin rd_gap0 = cyc - c0_0; c0_0 = cyc; rd_cnt0++; end
    if (bus1.ptr_fifo_rd) c0_1 = cyc;
    if (bus0.tx_dv) begin
      dv_cnt0++;
      if (eq0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected_dv actual=0x%0h required=none", bus0.tx_data);
      end else begin
        e = eq0.pop_front();
        cmp_byte("dut0", e, bus0.tx_sof, bus0.tx_data, cyc - c0_0, fc0);
      end
    end
    if (bus1.tx_dv) begin
      if (bus1.tx_sof) begin sof_gap1 = cyc - last_sof1; last_sof1 = cyc; end
      if (eq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_dv actual=0x%0h required=none", bus1.tx_data);
      end else begin
        e = eq1.pop_front();
        cmp_byte("dut1", e, bus1.tx_sof, bus1.tx_data, cyc - c0_1, fc1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_cyc, dv_base;
    bit hit;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tx_dv", bus0.tx_dv, 0);
    chk("rst_tx_sof", bus0.tx_sof, 0);
    chk("rst_tx_data", bus0.tx_data, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_frame_cnt", fc0, 0);
    chk("rst_data_rd", bus0.data_fifo_rd, 0);
    chk("rst_dut1_tx_dv", bus1.tx_dv, 0);
    chk("rst_dut1_frame_cnt", fc1, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // 5-byte frame with header: hl = 7
    ex(0, 1, 8'h01, 2, -1);
    ex(0, 0, 8'h07, 3, -1);
    for (int i = 0; i < 5; i++) begin
      dq0.push_back(8'(8'hA0 + i));
      ex(0, 0, 8'(8'hA0 + i), 4 + i, (i == 4) ? 1 : -1);
    end
    pq0.push_back(16'h0005);
    wait_done(0, 60, "t1_done");
    chk("t1_frame_cnt", fc0, 1);

    // zero-length descriptor then a 1-byte frame
    pq0.push_back(16'hF000);
    pq0.push_back(16'h0001);
    dq0.push_back(8'h5A);
    ex(0, 1, 8'h01, 2, -1);
    ex(0, 0, 8'h03, 3, -1);
    ex(0, 0, 8'h5A, 4, 2);
    wait_done(0, 60, "t3_done");
    chk("t3_err_count", err_cnt0, 1);
    chk("t3_err_cycle", err_off0, 1);
    chk("t3_reread_gap", rd_gap0, 2);

    // 4094-byte frame: hl wraps to 0
    dv_base = dv_cnt0;
    ex(0, 1, 8'h01, 2, -1);
    ex(0, 0, 8'h00, 3, -1);
    for (int i = 0; i < 4094; i++) begin
      dq0.push_back(8'(i));
      ex(0, 0, 8'(i), 4 + i, (i == 4093) ? 3 : -1);
    end
    pq0.push_back(16'h0FFE);
    wait_done(0, 4300, "t4_done");
    chk("t4_dv_cycles", dv_cnt0 - dv_base, 4096);

    // tx_hold before start blocks the read; mid-frame it is ignored
    hold0 = 1'b1;
    pq0.push_back(16'h0002);
    dq0.push_back(8'hC1);
    dq0.push_back(8'hC2);
    ex(0, 1, 8'h01, 2, -1);
    ex(0, 0, 8'h04, 3, -1);
    ex(0, 0, 8'hC1, 4, -1);
    ex(0, 0, 8'hC2, 5, 4);
    base = rd_cnt0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_read_on_hold", rd_cnt0, base);
    hold0 = 1'b0;
    base_cyc = cyc;
    @(negedge clk); #1;
    chk("t5_read_count", rd_cnt0, base + 1);
    chk("t5_read_cycle", c0_0, base_cyc);
    while (cyc < c0_0 + 3) @(posedge clk);
    #1 hold0 = 1'b1;
    wait_done(0, 60, "t5_done");
    hold0 = 1'b0;

    // header off, IFG 3, back-to-back descriptors
    pq1.push_back(16'h0001);
    pq1.push_back(16'h0002);
    dq1.push_back(8'h11);
    dq1.push_back(8'h22);
    dq1.push_back(8'h33);
    ex(1, 1, 8'h11, 4, 1);
    ex(1, 1, 8'h22, 4, -1);
    ex(1, 0, 8'h33, 5, 2);
    wait_done(1, 80, "t2_done");
    chk("t2_sof_spacing", sof_gap1, 8);
    chk("t2_frame_cnt", fc1, 2);

    // reset while payload byte 3 of a 10-byte frame is on the wire
    ex(0, 1, 8'h01, 2, -1);
    ex(0, 0, 8'h0C, 3, -1);
    for (int i = 0; i < 4; i++) ex(0, 0, 8'(8'hD0 + i), 4 + i, -1);
    for (int i = 0; i < 10; i++) dq0.push_back(8'(8'hD0 + i));
    pq0.push_back(16'h000A);
    base = rd_cnt0;
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk); #1;
      hit = (rd_cnt0 != base) && (cyc == c0_0 + 7);
    end
    chk("t6_reached_byte3", hit, 1);
    rstn = 1'b0;
    #1;
    chk("t6_bytes_before_reset", eq0.size(), 0);
    chk("t6_rst_tx_dv", bus0.tx_dv, 0);
    chk("t6_rst_tx_sof", bus0.tx_sof, 0);
    chk("t6_rst_tx_data", bus0.tx_data, 0);
    chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_frame_cnt", fc0, 0);
    chk("t6_rst_data_rd", bus0.data_fifo_rd, 0);
    chk("t6_rst_ptr_rd", bus0.ptr_fifo_rd, 0);
    chk("t6_rst_err", err0, 0);
    chk("t6_rst_dut1_frame_cnt", fc1, 0);
    pq0.delete();
    dq0.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    dq0.push_back(8'hEE);
    ex(0, 1, 8'h01, 2, -1);
    ex(0, 0, 8'h03, 3, -1);
    ex(0, 0, 8'hEE, 4, 1);
    pq0.push_back(16'h0001);
    wait_done(0, 60, "t6_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
